pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives hold-enables and flush/bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and taken-branch redirects.
- Freezes the pipeline through multi-cycle data-memory wait states, with a timeout that traps into a sticky error state.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_mem_wait_timer.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A load in EX whose destination is read by the instruction in ID.
  // x0 never carries a dependency.
  function automatic logic lu_hazard(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2,
    input logic       id_uses_rs2
  );
    return ex_mem_read && (ex_rd != REG_X0) &&
           ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_timer.sv
// Counts consecutive data-memory wait cycles and flags the timeout point.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic start,
  input  logic incr,
  output logic expired
);

  logic [7:0] wait_cnt;

  // Wait counter: start loads 1 because the entering cycle is already frozen.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= 8'd1;
    end else if (incr) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign expired = (wait_cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// taken-branch flushes, memory wait freeze with timeout trap.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic [1:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  state_t state_q;
  state_t next_state;
  logic   lu;
  logic   timer_clear;
  logic   timer_start;
  logic   timer_incr;
  logic   timer_expired;
  logic   set_err;

  assign lu    = lu_hazard(ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs2);
  assign state = state_q;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .start  (timer_start),
    .incr   (timer_incr),
    .expired(timer_expired)
  );

  // Mealy decode of enables, flushes and next state from (state, inputs).
  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    next_state    = ST_RUN;
    timer_clear   = 1'b0;
    timer_start   = 1'b0;
    timer_incr    = 1'b0;
    set_err       = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            mem_wb_bubble = 1'b1;
            timer_start   = 1'b1;
            next_state    = ST_MEM_WAIT;
          end else if (ex_branch_taken) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu) begin
            {id_ex_en, ex_mem_en, mem_wb_en} = '1;
            id_ex_flush = 1'b1;
          end else begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            timer_clear = 1'b1;
          end else if (timer_expired) begin
            mem_wb_bubble = 1'b1;
            set_err       = 1'b1;
            next_state    = ST_ERROR;
          end else begin
            mem_wb_bubble = 1'b1;
            timer_incr    = 1'b1;
            next_state    = ST_MEM_WAIT;
          end
        end
        ST_ERROR: begin
          mem_wb_bubble = 1'b1;
          next_state    = ST_ERROR;
        end
        default: begin
          next_state = ST_RUN;
        end
      endcase
    end
  end

  // State, sticky error flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      mem_err     <= 1'b0;
      stall_count <= '0;
    end else begin
      state_q <= next_state;
      if (set_err) begin
        mem_err <= 1'b1;
      end
      if (!pc_en && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule
